// File: rtl/ifft_sched_pkg.sv
// Shared types and default constants for the IFFT frame scheduler.
// The optional statistics counters are enabled by IFFT_FRAME_SCHED_STATS_EN.
package ifft_sched_pkg;

  localparam int DW_D         = 17;
  localparam int FRAME_LEN_D  = 128;
  localparam int GAP_CYCLES_D = 4;
  localparam int TAG_DEPTH_D  = 4;
  localparam int OUT_W        = 48;

  typedef logic signed [DW_D-1:0] sample_t;
  typedef logic src_id_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    GAP    = 2'd2
  } sched_state_e;

endpackage

// File: rtl/ifft_tag_fifo.sv
// Source-id FIFO tracking frames in flight through the decoder.
// Push while full is honoured only together with a pop.
module ifft_tag_fifo
  import ifft_sched_pkg::*;
#(
  parameter int DEPTH = TAG_DEPTH_D
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  src_id_t din,
  input  logic    pop,
  output src_id_t head,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wp;
  logic [AW:0] rp;
  src_id_t     mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) &&
                   (wp[AW-1:0] == rp[AW-1:0]);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign head    = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ifft_frame_sched.sv
// Two-source round-robin frame scheduler feeding the OFDM decoder.
// Define IFFT_FRAME_SCHED_STATS_EN to add frame/stall counters.
module ifft_frame_sched
  import ifft_sched_pkg::*;
#(
  parameter int FRAME_LEN  = FRAME_LEN_D,
  parameter int GAP_CYCLES = GAP_CYCLES_D,
  parameter int TAG_DEPTH  = TAG_DEPTH_D,
  parameter int DW         = DW_D
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 S0Valid,
  output logic                 S0Ready,
  input  logic signed [DW-1:0] S0DinR,
  input  logic signed [DW-1:0] S0DinI,
  input  logic                 S1Valid,
  output logic                 S1Ready,
  input  logic signed [DW-1:0] S1DinR,
  input  logic signed [DW-1:0] S1DinI,
  output logic                 Pushin,
  output logic                 FirstData,
  output logic signed [DW-1:0] DinR,
  output logic signed [DW-1:0] DinI,
  input  logic                 PushOut,
  input  logic [OUT_W-1:0]     DataOut,
  output logic                 OutValid,
  output logic [OUT_W-1:0]     OutData,
  output logic                 OutSrc,
  output logic                 Busy,
  output logic                 Overflow
`ifdef IFFT_FRAME_SCHED_STATS_EN
  ,
  output logic [15:0]          FrameCnt0,
  output logic [15:0]          FrameCnt1,
  output logic [15:0]          StallCnt
`endif
);

  localparam int CW = $clog2(FRAME_LEN);
  localparam int GW = $clog2(GAP_CYCLES + 1) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  sched_state_e    state;
  sched_state_e    nxt;
  src_id_t         gnt;
  src_id_t         gnt_nxt;
  src_id_t         rr;
  src_id_t         rr_nxt;
  logic [CW-1:0]   cnt;
  logic [GW-1:0]   gap_cnt;
  logic            hs;
  logic            last;
  logic            gap_last;
  logic            vld;
  logic            tag_push;
  logic            tag_full;
  logic            tag_empty;
  src_id_t         tag_head;
  logic signed [DW-1:0] sel_r;
  logic signed [DW-1:0] sel_i;

  assign vld      = gnt ? S1Valid : S0Valid;
  assign sel_r    = gnt ? S1DinR : S0DinR;
  assign sel_i    = gnt ? S1DinI : S0DinI;
  assign hs       = (state == STREAM) && vld;
  assign last     = (cnt == CNT_LAST);
  assign gap_last = (gap_cnt == GAP_LAST);
  assign S0Ready  = (state == STREAM) && !gnt;
  assign S1Ready  = (state == STREAM) && gnt;
  assign Busy     = (state != IDLE);

  always_comb begin
    nxt      = state;
    gnt_nxt  = gnt;
    rr_nxt   = rr;
    tag_push = 1'b0;
    unique case (state)
      IDLE: begin
        if ((S0Valid || S1Valid) && !tag_full) begin
          nxt      = STREAM;
          tag_push = 1'b1;
          gnt_nxt  = (S0Valid && S1Valid) ? rr : S1Valid;
          rr_nxt   = ~gnt_nxt;
        end
      end
      STREAM: begin
        if (hs && last)
          nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (gap_last) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      rr        <= 1'b0;
      cnt       <= '0;
      gap_cnt   <= '0;
      Pushin    <= 1'b0;
      FirstData <= 1'b0;
      DinR      <= '0;
      DinI      <= '0;
    end else begin
      state     <= nxt;
      gnt       <= gnt_nxt;
      rr        <= rr_nxt;
      Pushin    <= hs;
      FirstData <= hs && (cnt == '0);
      if (hs) begin
        DinR <= sel_r;
        DinI <= sel_i;
        cnt  <= last ? '0 : cnt + 1'b1;
      end
      if (state == GAP && !gap_last)
        gap_cnt <= gap_cnt + 1'b1;
      else
        gap_cnt <= '0;
    end
  end

  ifft_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tags (
    .clk   (Clk),
    .rst_n (Reset),
    .push  (tag_push),
    .din   (gnt_nxt),
    .pop   (PushOut),
    .head  (tag_head),
    .full  (tag_full),
    .empty (tag_empty)
  );

  // Result with no tag outstanding is reported as source 0.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      OutValid <= 1'b0;
      OutData  <= '0;
      OutSrc   <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      OutValid <= PushOut;
      if (PushOut) begin
        OutData <= DataOut;
        OutSrc  <= tag_empty ? 1'b0 : tag_head;
        if (tag_empty) Overflow <= 1'b1;
      end
    end
  end

`ifdef IFFT_FRAME_SCHED_STATS_EN
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      FrameCnt0 <= '0;
      FrameCnt1 <= '0;
      StallCnt  <= '0;
    end else begin
      if (hs && last && !gnt) FrameCnt0 <= FrameCnt0 + 1'b1;
      if (hs && last && gnt)  FrameCnt1 <= FrameCnt1 + 1'b1;
      if (state == STREAM && !vld)
        StallCnt <= StallCnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ifft_frame_sched.sv
// Directed self-checking bench for ifft_frame_sched.
// Uses default parameters: 128-sample frames, 4-cycle gap, 4 tags.
module tb_ifft_frame_sched;

  localparam int DW  = 17;
  localparam int FL  = 128;
  localparam int GAP = 4;

  logic                 Clk = 1'b0;
  logic                 Reset = 1'b0;
  logic                 S0Valid = 1'b0;
  logic                 S0Ready;
  logic signed [DW-1:0] S0DinR = '0;
  logic signed [DW-1:0] S0DinI = '0;
  logic                 S1Valid = 1'b0;
  logic                 S1Ready;
  logic signed [DW-1:0] S1DinR = '0;
  logic signed [DW-1:0] S1DinI = '0;
  logic                 Pushin;
  logic                 FirstData;
  logic signed [DW-1:0] DinR;
  logic signed [DW-1:0] DinI;
  logic                 PushOut = 1'b0;
  logic [47:0]          DataOut = '0;
  logic                 OutValid;
  logic [47:0]          OutData;
  logic                 OutSrc;
  logic                 Busy;
  logic                 Overflow;
`ifdef IFFT_FRAME_SCHED_STATS_EN
  logic [15:0]          FrameCnt0;
  logic [15:0]          FrameCnt1;
  logic [15:0]          StallCnt;
`endif

  int checks = 0;
  int errors = 0;
  int k0 = 0;
  int k1 = 0;

  always #5 Clk = ~Clk;

  ifft_frame_sched dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .S0Valid   (S0Valid),
    .S0Ready   (S0Ready),
    .S0DinR    (S0DinR),
    .S0DinI    (S0DinI),
    .S1Valid   (S1Valid),
    .S1Ready   (S1Ready),
    .S1DinR    (S1DinR),
    .S1DinI    (S1DinI),
    .Pushin    (Pushin),
    .FirstData (FirstData),
    .DinR      (DinR),
    .DinI      (DinI),
    .PushOut   (PushOut),
    .DataOut   (DataOut),
    .OutValid  (OutValid),
    .OutData   (OutData),
    .OutSrc    (OutSrc),
    .Busy      (Busy),
    .Overflow  (Overflow)
`ifdef IFFT_FRAME_SCHED_STATS_EN
    ,
    .FrameCnt0 (FrameCnt0),
    .FrameCnt1 (FrameCnt1),
    .StallCnt  (StallCnt)
`endif
  );

  // Sample k of source 0 is (3k+1, -k); of source 1 is (20000+k, 5k).
  task automatic drive_data();
    S0DinR = DW'(k0 * 3 + 1);
    S0DinI = DW'(-k0);
    S1DinR = DW'(20000 + k1);
    S1DinI = DW'(k1 * 5);
  endtask

  task automatic tick();
    logic h0;
    logic h1;
    h0 = S0Valid && S0Ready;
    h1 = S1Valid && S1Ready;
    @(posedge Clk);
    #1;
    if (h0) k0++;
    if (h1) k1++;
    drive_data();
  endtask

  task automatic do_reset();
    Reset   = 1'b0;
    S0Valid = 1'b0;
    S1Valid = 1'b0;
    PushOut = 1'b0;
    DataOut = '0;
    tick();
    tick();
    Reset = 1'b1;
    k0 = 0;
    k1 = 0;
    drive_data();
  endtask

  task automatic test_reset();
    logic [31:0] got;
    do_reset();
    got = {Pushin, FirstData, OutValid, OutSrc, Busy, Overflow,
           S0Ready, S1Ready, (DinR != 0), (DinI != 0), (OutData != 0)};
    checks++;
    if (got !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0", got);
    end
  endtask

  task automatic test_single();
    logic rdy [400];
    logic psh [400];
    logic fd  [400];
    logic bsy [400];
    logic signed [DW-1:0] dr [400];
    logic signed [DW-1:0] di [400];
    int t_r1;
    int t_f;
    int t_r2;
    int bad;
    int nfd;
    int nidle;
    do_reset();
    S0Valid = 1'b1;
    for (int t = 0; t < 400; t++) begin
      tick();
      rdy[t] = S0Ready;
      psh[t] = Pushin;
      fd[t]  = FirstData;
      bsy[t] = Busy;
      dr[t]  = DinR;
      di[t]  = DinI;
    end
    S0Valid = 1'b0;
    t_r1 = -1;
    t_f  = -1;
    t_r2 = -1;
    for (int t = 0; t < 400; t++) begin
      if (t_r1 < 0 && rdy[t]) t_r1 = t;
      else if (t_r1 >= 0 && t_f < 0 && !rdy[t]) t_f = t;
      else if (t_f >= 0 && t_r2 < 0 && rdy[t]) t_r2 = t;
    end
    checks++;
    if (t_r1 < 0 || t_f < 0 || t_r2 < 0 || t_r2 > 390) begin
      errors++;
      $display("FAIL single_ready_edges: got %0d %0d %0d", t_r1, t_f, t_r2);
      return;
    end
    checks++;
    if (t_f - t_r1 !== FL) begin
      errors++;
      $display("FAIL single_frame_len: got %0d want %0d", t_f - t_r1, FL);
    end
    checks++;
    if (t_r2 - t_f !== GAP + 1) begin
      errors++;
      $display("FAIL single_ready_gap: got %0d want %0d", t_r2 - t_f, GAP + 1);
    end
    bad = 0;
    for (int t = t_r1; t <= t_r2; t++) begin
      if (psh[t] !== (t > t_r1 && t <= t_f)) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL single_push_window: got %0d wrong cycles want 0", bad);
    end
    nfd = 0;
    for (int t = 0; t <= t_r2; t++) if (fd[t]) nfd++;
    checks++;
    if (nfd !== 1 || fd[t_r1 + 1] !== 1'b1) begin
      errors++;
      $display("FAIL single_firstdata: got %0d pulses want 1 on first push", nfd);
    end
    bad = 0;
    for (int t = t_r1 + 1; t <= t_f; t++) begin
      if (dr[t] !== DW'((t - t_r1 - 1) * 3 + 1)) bad++;
      if (di[t] !== DW'(-(t - t_r1 - 1))) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL single_data: got %0d wrong samples want 0", bad);
    end
    nidle = 0;
    for (int t = t_f; t <= t_r2; t++) if (!bsy[t]) nidle++;
    checks++;
    if (nidle !== 1) begin
      errors++;
      $display("FAIL single_busy_idle: got %0d idle cycles want 1", nidle);
    end
    checks++;
    if (fd[t_r2 + 1] !== 1'b1 || dr[t_r2 + 1] !== DW'(FL * 3 + 1)) begin
      errors++;
      $display("FAIL single_second_frame: got fd=%0d dinr=%0d want 1 %0d",
               fd[t_r2 + 1], dr[t_r2 + 1], FL * 3 + 1);
    end
  endtask

  task automatic test_round_robin();
    int order [$];
    int fdv [$];
    logic p0;
    logic p1;
    int both;
    do_reset();
    S0Valid = 1'b1;
    S1Valid = 1'b1;
    p0 = 1'b0;
    p1 = 1'b0;
    both = 0;
    for (int t = 0; t < 800 && order.size() < 4; t++) begin
      tick();
      if (S0Ready && S1Ready) both++;
      if (S0Ready && !p0) order.push_back(0);
      if (S1Ready && !p1) order.push_back(1);
      if (FirstData) fdv.push_back(int'(DinR));
      p0 = S0Ready;
      p1 = S1Ready;
    end
    checks++;
    if (order.size() !== 4) begin
      errors++;
      $display("FAIL rr_grant_count: got %0d want 4", order.size());
      return;
    end
    checks++;
    if (order[0] !== 0 || order[1] !== 1 || order[2] !== 0 || order[3] !== 1) begin
      errors++;
      $display("FAIL rr_order: got %0d%0d%0d%0d want 0101",
               order[0], order[1], order[2], order[3]);
    end
    checks++;
    if (both !== 0) begin
      errors++;
      $display("FAIL rr_exclusive_ready: got %0d overlaps want 0", both);
    end
    checks++;
    if (fdv.size() < 3 || fdv[0] !== 1 || fdv[1] !== 20000 || fdv[2] !== FL * 3 + 1) begin
      errors++;
      $display("FAIL rr_first_samples: got %0d entries want 1 20000 %0d",
               fdv.size(), FL * 3 + 1);
    end
  endtask

  task automatic test_tag_full();
    int wait_n;
    int bad;
    int exp_src [3];
    exp_src[0] = 1;
    exp_src[1] = 0;
    exp_src[2] = 1;
    wait_n = 0;
    while (Busy && wait_n < 600) begin
      tick();
      wait_n++;
    end
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL full_reach_idle: got busy=%0d want 0", Busy);
      return;
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (S0Ready || S1Ready || Busy) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL full_blocked: got %0d active cycles want 0", bad);
    end
    PushOut = 1'b1;
    DataOut = 48'hA5A5_0000_1234;
    tick();
    PushOut = 1'b0;
    DataOut = '0;
    checks++;
    if (OutValid !== 1'b1 || OutData !== 48'hA5A5_0000_1234 || OutSrc !== 1'b0) begin
      errors++;
      $display("FAIL full_result: got v=%0d d=%h s=%0d want 1 a5a500001234 0",
               OutValid, OutData, OutSrc);
    end
    tick();
    checks++;
    if (S0Ready !== 1'b1 || S1Ready !== 1'b0 || OutValid !== 1'b0) begin
      errors++;
      $display("FAIL full_fifth_grant: got r0=%0d r1=%0d v=%0d want 1 0 0",
               S0Ready, S1Ready, OutValid);
    end
    for (int i = 0; i < 3; i++) begin
      PushOut = 1'b1;
      DataOut = 48'(i + 7);
      tick();
      PushOut = 1'b0;
      checks++;
      if (OutValid !== 1'b1 || OutSrc !== exp_src[i][0] || OutData !== 48'(i + 7)) begin
        errors++;
        $display("FAIL full_drain_%0d: got v=%0d s=%0d d=%0d want 1 %0d %0d",
                 i, OutValid, OutSrc, OutData, exp_src[i], i + 7);
      end
    end
    checks++;
    if (Overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_no_overflow: got %0d want 0", Overflow);
    end
  endtask

  task automatic test_stall();
    int npush;
    int nfd;
    int first_t;
    int last_t;
    int t49;
    int t50;
    int bad;
    int dropped;
    logic seen;
    do_reset();
    S0Valid = 1'b1;
    npush = 0;
    nfd = 0;
    first_t = -1;
    last_t = -1;
    t49 = -1;
    t50 = -1;
    bad = 0;
    dropped = 0;
    seen = 1'b0;
    for (int t = 0; t < 400; t++) begin
      tick();
      if (Pushin) begin
        if (first_t < 0) first_t = t;
        last_t = t;
        if (npush == 49) t49 = t;
        if (npush == 50) t50 = t;
        if (DinR !== DW'(npush * 3 + 1) || DinI !== DW'(-npush)) bad++;
        npush++;
      end
      if (FirstData) nfd++;
      if (S0Ready) seen = 1'b1;
      if (seen && !S0Ready && !Busy) break;
      if (seen && !S0Ready) begin
        S0Valid = 1'b0;
      end else if (k0 == 50 && dropped < 3) begin
        S0Valid = 1'b0;
        dropped++;
      end else begin
        S0Valid = 1'b1;
      end
    end
    S0Valid = 1'b0;
    checks++;
    if (npush !== FL) begin
      errors++;
      $display("FAIL stall_push_count: got %0d want %0d", npush, FL);
    end
    checks++;
    if (nfd !== 1) begin
      errors++;
      $display("FAIL stall_firstdata: got %0d want 1", nfd);
    end
    checks++;
    if (t50 - t49 !== 4 || last_t - first_t !== FL + 2) begin
      errors++;
      $display("FAIL stall_hole: got gap %0d span %0d want 4 %0d",
               t50 - t49, last_t - first_t, FL + 2);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL stall_data: got %0d wrong samples want 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic r1_seen;
    do_reset();
    S1Valid = 1'b1;
    n = 0;
    while (k1 < 70 && n < 300) begin
      tick();
      n++;
    end
    Reset = 1'b0;
    tick();
    checks++;
    if (Pushin !== 1'b0 || Busy !== 1'b0 || S1Ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_abort: got p=%0d b=%0d r1=%0d want 0 0 0",
               Pushin, Busy, S1Ready);
    end
    Reset = 1'b1;
    S0Valid = 1'b1;
    S1Valid = 1'b1;
    k0 = 0;
    k1 = 0;
    drive_data();
    r1_seen = 1'b0;
    n = 0;
    do begin
      tick();
      if (S1Ready) r1_seen = 1'b1;
      n++;
    end while (!Pushin && n < 10);
    checks++;
    if (FirstData !== 1'b1 || DinR !== DW'(1) || r1_seen !== 1'b0) begin
      errors++;
      $display("FAIL midreset_regrant: got fd=%0d dinr=%0d r1=%0d want 1 1 0",
               FirstData, DinR, r1_seen);
    end
    PushOut = 1'b1;
    DataOut = 48'h55;
    tick();
    PushOut = 1'b0;
    checks++;
    if (OutValid !== 1'b1 || OutSrc !== 1'b0 || Overflow !== 1'b0) begin
      errors++;
      $display("FAIL midreset_flush: got v=%0d s=%0d o=%0d want 1 0 0",
               OutValid, OutSrc, Overflow);
    end
  endtask

  task automatic test_overflow();
    int bad;
    do_reset();
    PushOut = 1'b1;
    DataOut = 48'h1;
    tick();
    PushOut = 1'b0;
    DataOut = '0;
    checks++;
    if (OutValid !== 1'b1 || OutSrc !== 1'b0 || Overflow !== 1'b1 || OutData !== 48'h1) begin
      errors++;
      $display("FAIL ovf_set: got v=%0d s=%0d o=%0d want 1 0 1",
               OutValid, OutSrc, Overflow);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (Overflow !== 1'b1 || OutValid !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL ovf_sticky: got %0d bad cycles want 0", bad);
    end
    do_reset();
    checks++;
    if (Overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_reset_clear: got %0d want 0", Overflow);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_tag_full();
    test_stall();
    test_reset_mid();
    test_overflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
